// File: rtl/instruction_fetch_system_if.sv
// Instruction memory bus between the fetch stage (master) and the instruction memory (slave).
// The request holds a stable word address until acknowledged; read data is valid with the ack.
interface instruction_fetch_system_if;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_addr,
    output mem_req,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_addr,
    input  mem_req,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/instruction_fetch_system.sv
// Fetch stage: owns the PC, fetches one- or two-word instructions, and holds IR/ImR/ra_out
// for the execution stage until it signals completion and picks the next PC.
module instruction_fetch_system #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                               clk,
  input  logic                               reset,
  instruction_fetch_system_if.master         mem,
  input  logic                               advance,
  input  logic [1:0]                         pc_sel,
  input  logic                               cmp_result,
  input  logic [15:0]                        ra_in,
  output logic [15:0]                        IR,
  output logic [15:0]                        ImR,
  output logic [15:0]                        ra_out,
  output logic [15:0]                        instr_addr,
  output logic                               valid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ_I = 2'd1;
  localparam logic [1:0] REQ_X = 2'd2;
  localparam logic [1:0] READY = 2'd3;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SEL_RETURN = 2'b11;

  logic [1:0]  state;
  logic [15:0] pc;
  logic        two_word;
  logic [15:0] short_imm;

  // Opcodes 0xC-0xF carry a second (extension) word.
  assign two_word  = (mem.mem_rdata[15:12] >= 4'hC);
  assign short_imm = {{8{mem.mem_rdata[7]}}, mem.mem_rdata[7:0]};

  assign mem.mem_addr = pc;
  assign mem.mem_req  = (state == REQ_I) || (state == REQ_X);
  assign valid        = (state == READY);
  assign ra_out       = pc;

  // NOTE: every register here, state included, uses non-blocking assignment so that all
  // updates within one edge see the pre-edge values (e.g. ImR used while pc is rewritten).
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and checked first, so it also abandons an in-flight fetch.
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      IR         <= 16'h0000;
      ImR        <= 16'h0000;
      instr_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ_I;
        end

        REQ_I: begin
          if (mem.mem_ack) begin
            IR         <= mem.mem_rdata;
            ImR        <= short_imm;
            instr_addr <= pc;
            pc         <= pc + 16'd1;
            state      <= two_word ? REQ_X : READY;
          end
        end

        REQ_X: begin
          if (mem.mem_ack) begin
            ImR   <= mem.mem_rdata;
            pc    <= pc + 16'd1;
            state <= READY;
          end
        end

        READY: begin
          if (advance) begin
            state <= REQ_I;
            // pc already points past the instruction, so sequential needs no update.
            case (pc_sel)
              SEL_SEQ:    pc <= pc;
              SEL_BRANCH: if (cmp_result) pc <= ImR;
              SEL_JUMP:   pc <= ImR;
              SEL_RETURN: pc <= ra_in;
              default:    pc <= pc;
            endcase
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch_system.md
# instruction_fetch_system

Fetch stage directly upstream of the instruction execution system. Owns the program counter, fetches one- or two-word instructions from word-addressed instruction memory over a req/ack handshake, and presents IR, ImR and the return address RAIn to the execution stage. It holds the instruction until the control unit signals completion, then selects the next PC: sequential, conditional branch on `cmp_result`, jump to ImR, or return to the saved RA.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded by reset.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `mem_addr`  out  16  instruction memory word address.
- `mem_req`  out  1  fetch request; high with stable `mem_addr` until acknowledged.
- `mem_rdata`  in  16  instruction memory read data; valid in the cycle `mem_ack` is high.
- `mem_ack`  in  1  memory acknowledge; may be high in the same cycle as `mem_req`.
- `advance`  in  1  control unit: current instruction finished; take next-PC decision.
- `pc_sel`  in  2  next-PC select, sampled with `advance`: 00 sequential, 01 branch-if-`cmp_result`, 10 jump to ImR, 11 return to `ra_in`.
- `cmp_result`  in  1  comparison result from the execution stage.
- `ra_in`  in  16  saved return address from the execution stage (its RAOut).
- `IR`  out  16  current instruction word.
- `ImR`  out  16  immediate: extension word, or sign-extended IR[7:0].
- `ra_out`  out  16  address of the word after the current instruction (feeds RAIn).
- `instr_addr`  out  16  address of the current instruction's first word.
- `valid`  out  1  IR/ImR/ra_out hold a complete instruction.

## Operation
- States: IDLE, REQ_I, REQ_X, READY. Reset state is IDLE; IDLE → REQ_I unconditionally on the next cycle.
- Registers: `pc` (16), `IR`, `ImR`, `instr_addr`. `mem_addr` = `pc`. `mem_req` = (state is REQ_I or REQ_X). `valid` = (state is READY). `ra_out` = `pc`.
- REQ_I: wait for `mem_ack`. On ack: IR ← mem_rdata; instr_addr ← pc; pc ← pc+1; ImR ← {{8{rdata[7]}}, rdata[7:0]}.
  - If rdata[15:12] ≥ 4'hC (two-word opcode), go to REQ_X.
  - Otherwise go to READY.
- REQ_X: wait for `mem_ack`. On ack: ImR ← mem_rdata; pc ← pc+1; go to READY.
- READY: hold all outputs. On `advance`, update pc and go to REQ_I.
  - 00: pc unchanged (already points past the instruction).
  - 01: pc ← `cmp_result` ? ImR : pc.
  - 10: pc ← ImR.
  - 11: pc ← `ra_in`.
- PC arithmetic is 16-bit modulo; 16'hFFFF + 1 = 16'h0000. A two-word instruction may straddle the wrap.
- `mem_ack` outside REQ_I/REQ_X is ignored. `advance` outside READY is ignored and is not remembered.
- Reset has priority over every other event, including reset asserted mid-fetch.
  - The outstanding request is abandoned, and `mem_req` is low in the cycle after reset is sampled.
  - Memory must tolerate an abandoned request.

## Timing
- Reset values (cycle after reset sampled high): pc = instr_addr = ra_out = `mem_addr` = RESET_PC; IR = ImR = 0; `mem_req` = 0; `valid` = 0; state IDLE.
- First `mem_req` occurs 1 cycle after reset deasserts.
- Zero-wait memory (ack in the request cycle):
  - One-word instruction: req cycle, then `valid` the next cycle.
  - Two-word instruction: 2 req cycles, then `valid`.
- Each wait cycle (req high, ack low) adds one cycle; `mem_addr` is stable throughout.
- `advance` sampled in READY: `valid` drops and `mem_req` rises at the new `mem_addr` on the next cycle. There is no bubble beyond this.
- Minimum throughput: one one-word instruction every 2 cycles.

## Test plan
- Reset, RESET_PC=16'h0010, zero-wait memory holding 16'h1234 at 0x0010:
  - → first `mem_req` 1 cycle after reset with addr 0x0010.
  - Next cycle: `valid`=1, IR=16'h1234, ImR=16'h0034, instr_addr=0x0010, ra_out=0x0011.
- Two-word fetch: memory 0x0020=16'hC0FF, 0x0021=16'hBEEF, ack delayed 2 cycles on each word → `mem_addr` held 3 cycles each, then IR=16'hC0FF, ImR=16'hBEEF, ra_out=0x0022.
- Branch sequence:
  - One-word IR=16'h30F0 (ImR=16'hFFF0) at 0x0040, `advance` with `pc_sel`=01, `cmp_result`=1 → next fetch address 0xFFF0.
  - Repeat with `cmp_result`=0 → 0x0041.
- Jump and return:
  - `pc_sel`=10 with ImR=16'h0100 → next fetch 0x0100.
  - `pc_sel`=11 with `ra_in`=16'h0055 → next fetch 0x0055.
- Wrap: two-word instruction at 0xFFFF → extension fetched from 0x0000, ra_out=0x0001.
- Reset mid-fetch: assert reset while in REQ_X with ack low → next cycle `mem_req`=0, `valid`=0, IR=ImR=0, pc=RESET_PC; fetch restarts at RESET_PC. Stray `advance`/`mem_ack` during IDLE change nothing.
